// File: rtl/practise_sim.sv
// Serial bit-pattern detector: pulses y one cycle after the last PATTERN_LEN
// sampled bits of x equal PATTERN (earliest bit at the MSB, overlaps allowed).
module practise_sim #(
   parameter int                     PATTERN_LEN = 4,
   parameter logic [PATTERN_LEN-1:0] PATTERN     = 4'b0101
) (
   input  logic clk,
   input  logic reset,
   input  logic x,
   output logic y
);

   localparam int FW = $clog2(PATTERN_LEN + 1);
   localparam logic [FW-1:0] FULL = FW'(PATTERN_LEN);

   logic [PATTERN_LEN-1:0] hist, hist_nxt;
   logic [FW-1:0]          fill, fill_nxt;
   logic                   hit_nxt;

   generate
      if (PATTERN_LEN == 1) begin : g_one
         assign hist_nxt = x;
      end else begin : g_many
         assign hist_nxt = {hist[PATTERN_LEN-2:0], x};
      end
   endgenerate

   // fill gates the compare so zero-initialised history never matches
   assign fill_nxt = (fill == FULL) ? fill : fill + FW'(1);
   assign hit_nxt  = (hist_nxt == PATTERN) && (fill_nxt == FULL);

   always_ff @(posedge clk) begin
      if (reset) begin
         hist <= '0;
         fill <= '0;
         y    <= 1'b0;
      end else begin
         hist <= hist_nxt;
         fill <= fill_nxt;
         y    <= hit_nxt;
      end
   end

endmodule

// File: tb/tb_practise_sim.sv
// Bench for practise_sim: directed steps plus random traffic, checked against
// a queue of bits received since the last reset.
module tb_practise_sim;

   logic clk = 1'b0;
   logic reset;
   logic x;
   logic y, yz;

   int n_chk  = 0;
   int n_fail = 0;

   localparam logic [3:0] PAT_A = 4'b0101;
   localparam logic [3:0] PAT_Z = 4'b0000;

   bit q[$];

   practise_sim #(.PATTERN_LEN(4), .PATTERN(PAT_A)) u_dut (
      .clk(clk), .reset(reset), .x(x), .y(y));

   practise_sim #(.PATTERN_LEN(4), .PATTERN(PAT_Z)) u_zero (
      .clk(clk), .reset(reset), .x(x), .y(yz));

   always #5 clk = ~clk;

   function automatic logic match(input logic [3:0] p);
      if (q.size() != 4) return 1'b0;
      for (int i = 0; i < 4; i++)
         if (q[i] != p[3-i]) return 1'b0;
      return 1'b1;
   endfunction

   // exp < 0 means no directed expectation, model check only
   task automatic step(input logic r, input logic b, input int exp, input string tag);
      logic ma, mz;
      @(negedge clk);
      reset = r;
      x     = b;
      @(posedge clk);
      #1;
      if (r) q.delete();
      else begin
         q.push_back(b);
         if (q.size() > 4) void'(q.pop_front());
      end
      ma = match(PAT_A);
      mz = match(PAT_Z);
      n_chk++;
      assert (y === ma) else begin
         n_fail++;
         $error("FAIL %s model: y=%b expected %b", tag, y, ma);
      end
      n_chk++;
      assert (yz === mz) else begin
         n_fail++;
         $error("FAIL %s zero-pattern: y=%b expected %b", tag, yz, mz);
      end
      if (exp >= 0) begin
         n_chk++;
         assert (y === exp[0]) else begin
            n_fail++;
            $error("FAIL %s directed: y=%b expected %b", tag, y, exp[0]);
         end
      end
   endtask

   task automatic run_seq(input logic [15:0] bits, input logic [15:0] exps,
                          input int n, input string tag);
      logic [15:0] bv, ev;
      bv = bits;
      ev = exps;
      step(1'b1, 1'b0, 0, {tag, "_rst"});
      for (int i = 0; i < n; i++)
         step(1'b0, bv[n-1-i], int'(ev[n-1-i]), tag);
   endtask

   initial begin
      reset = 1'b1;
      x     = 1'b0;

      step(1'b1, 1'b0, 0, "reset0");
      step(1'b1, 1'b1, 0, "reset1");
      for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 0, "idle_ones");

      run_seq(16'b01011, 16'b00010, 5, "single");
      run_seq(16'b0101011, 16'b0001010, 7, "overlap");

      step(1'b1, 1'b0, 0, "mid_rst");
      step(1'b0, 1'b0, 0, "mid_pre");
      step(1'b0, 1'b1, 0, "mid_pre");
      step(1'b0, 1'b0, 0, "mid_pre");
      step(1'b1, 1'b1, 0, "mid_reset");
      step(1'b0, 1'b1, 0, "mid_post");
      step(1'b0, 1'b0, 0, "mid_post");
      step(1'b0, 1'b1, 0, "mid_post");
      step(1'b0, 1'b0, 0, "mid_post");
      step(1'b0, 1'b1, 1, "mid_post_hit");

      run_seq(16'b0011011010, 16'b0, 10, "near_miss");

      step(1'b1, 1'b0, 0, "zero_rst");
      for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 0, "zero_run");

      for (int i = 0; i < 1000; i++)
         step(($urandom_range(0, 49) == 0), 1'($urandom), -1, "random");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
